// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the IF/DE/MW hazard unit
package pipe_pkg;

   // Default architectural register-address width (32 registers)
   localparam int REG_AW_DEF = 5;

   // Hazard FSM: RUN advances freely, MEM_WAIT freezes the pipe for a slow load
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

   // Major opcodes the decoder keys on
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q, cnt_d;

   // Clear wins over increment; the count sticks at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   // Counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding control for the IF/DE/MW pipeline
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_valid_i,
   input  logic [REG_AW-1:0] de_rs1_addr_i,
   input  logic [REG_AW-1:0] de_rs2_addr_i,
   input  logic              de_rs1_used_i,
   input  logic              de_rs2_used_i,
   input  logic [REG_AW-1:0] de_rd_addr_i,
   input  logic              de_reg_write_i,
   input  logic              de_is_load_i,
   input  logic              de_redirect_i,
   input  logic              cnt_clr_i,
   output logic              pc_en_o,
   output logic              if_de_en_o,
   output logic              de_mw_en_o,
   output logic              if_de_flush_o,
   output logic              de_valid_o,
   output logic              mw_valid_o,
   output logic [REG_AW-1:0] mw_rd_addr_o,
   output logic              mw_reg_write_o,
   output logic              fwd_a_o,
   output logic              fwd_b_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   if ((MEM_LAT < 1) || (MEM_LAT > 8)) begin : g_bad_mem_lat
      $error("pipe_hazard_ctrl: MEM_LAT must lie in 1..8");
   end

   // Stalled cycles after a load enters MW; the load then writes in one more cycle
   localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

   hz_state_e         state_q, state_d;
   logic [2:0]        wait_q, wait_d;
   logic              de_valid_q, de_valid_d;
   logic              mw_valid_q, mw_valid_d;
   logic [REG_AW-1:0] mw_rd_q, mw_rd_d;
   logic              mw_rw_q, mw_rw_d;
   logic              mw_ld_q, mw_ld_d;
   logic              stall;
   logic              flush;

   assign stall = (state_q == MEM_WAIT);
   // A redirect seen while frozen is simply held in DE until the pipe moves again
   assign flush = de_redirect_i & de_valid_q & ~stall;

   // Stage advance: everything shifts one stage unless a slow load holds MW
   always_comb begin
      de_valid_d = de_valid_q;
      mw_valid_d = mw_valid_q;
      mw_rd_d    = mw_rd_q;
      mw_rw_d    = mw_rw_q;
      mw_ld_d    = mw_ld_q;
      if (!stall) begin
         de_valid_d = if_valid_i & ~flush;
         mw_valid_d = de_valid_q;
         mw_rd_d    = de_valid_q ? de_rd_addr_i : '0;
         mw_rw_d    = de_valid_q & de_reg_write_i;
         mw_ld_d    = de_valid_q & de_is_load_i;
      end
   end

   // Load-latency FSM: a valid load entering MW freezes the pipe for MEM_LAT-1 cycles
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (MEM_LAT > 1) begin
         case (state_q)
            RUN: begin
               if (de_valid_q && de_is_load_i) begin
                  state_d = MEM_WAIT;
                  wait_d  = WAIT_INIT;
               end
            end
            MEM_WAIT: begin
               wait_d = wait_q - 3'd1;
               // Never stay frozen without a load actually sitting in MW
               if ((wait_q == 3'd1) || !mw_ld_q) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         wait_q     <= 3'd0;
         de_valid_q <= 1'b0;
         mw_valid_q <= 1'b0;
         mw_rd_q    <= '0;
         mw_rw_q    <= 1'b0;
         mw_ld_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         de_valid_q <= de_valid_d;
         mw_valid_q <= mw_valid_d;
         mw_rd_q    <= mw_rd_d;
         mw_rw_q    <= mw_rw_d;
         mw_ld_q    <= mw_ld_d;
      end
   end

   assign stall_o        = stall;
   assign pc_en_o        = ~stall;
   assign if_de_en_o     = ~stall;
   assign de_mw_en_o     = ~stall;
   assign if_de_flush_o  = flush;
   assign de_valid_o     = de_valid_q;
   assign mw_valid_o     = mw_valid_q;
   assign mw_rd_addr_o   = mw_rd_q;
   // A load writes back only in its last MW cycle, once data has arrived
   assign mw_reg_write_o = mw_valid_q & mw_rw_q & ~stall;

   // MW -> DE bypass; x0 is hard-wired zero and never forwards
   assign fwd_a_o = de_valid_q & de_rs1_used_i & mw_valid_q & mw_rw_q &
                    (mw_rd_q != '0) & (mw_rd_q == de_rs1_addr_i);
   assign fwd_b_o = de_valid_q & de_rs2_used_i & mw_valid_q & mw_rw_q &
                    (mw_rd_q != '0) & (mw_rd_q == de_rs2_addr_i);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (stall),
      .clr_i (cnt_clr_i),
      .cnt_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush),
      .clr_i (cnt_clr_i),
      .cnt_o (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam int LAT  = 3;
   localparam int CW   = 8;
   localparam int AW   = 5;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_valid_i = 1'b0;
   logic [AW-1:0] de_rs1_addr_i = '0;
   logic [AW-1:0] de_rs2_addr_i = '0;
   logic          de_rs1_used_i = 1'b0;
   logic          de_rs2_used_i = 1'b0;
   logic [AW-1:0] de_rd_addr_i = '0;
   logic          de_reg_write_i = 1'b0;
   logic          de_is_load_i = 1'b0;
   logic          de_redirect_i = 1'b0;
   logic          cnt_clr_i = 1'b0;
   logic          pc_en_o, if_de_en_o, de_mw_en_o, if_de_flush_o;
   logic          de_valid_o, mw_valid_o, mw_reg_write_o, fwd_a_o, fwd_b_o, stall_o;
   logic [AW-1:0] mw_rd_addr_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(AW), .MEM_LAT(LAT), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .if_valid_i     (if_valid_i),
      .de_rs1_addr_i  (de_rs1_addr_i),
      .de_rs2_addr_i  (de_rs2_addr_i),
      .de_rs1_used_i  (de_rs1_used_i),
      .de_rs2_used_i  (de_rs2_used_i),
      .de_rd_addr_i   (de_rd_addr_i),
      .de_reg_write_i (de_reg_write_i),
      .de_is_load_i   (de_is_load_i),
      .de_redirect_i  (de_redirect_i),
      .cnt_clr_i      (cnt_clr_i),
      .pc_en_o        (pc_en_o),
      .if_de_en_o     (if_de_en_o),
      .de_mw_en_o     (de_mw_en_o),
      .if_de_flush_o  (if_de_flush_o),
      .de_valid_o     (de_valid_o),
      .mw_valid_o     (mw_valid_o),
      .mw_rd_addr_o   (mw_rd_addr_o),
      .mw_reg_write_o (mw_reg_write_o),
      .fwd_a_o        (fwd_a_o),
      .fwd_b_o        (fwd_b_o),
      .stall_o        (stall_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   typedef struct {
      bit stall, flush, de_v, mw_v, fa, fb, wr;
      int mw_rd, scnt, fcnt;
   } exp_t;

   exp_t exp_q[$];
   int   wb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: which instruction sits in each stage and how long the MW one has been there
   bit m_de_v, m_mw_v, m_mw_rw, m_mw_ld;
   int m_mw_rd, m_age, m_scnt, m_fcnt;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit ifv, input bit redir, input int rs1, input int rs2,
                        input bit u1, input bit u2, input int rd, input bit rw, input bit ld,
                        input bit clr);
      exp_t e;
      @(negedge clk);
      rst            = r;
      if_valid_i     = ifv;
      de_redirect_i  = redir;
      de_rs1_addr_i  = AW'(rs1);
      de_rs2_addr_i  = AW'(rs2);
      de_rs1_used_i  = u1;
      de_rs2_used_i  = u2;
      de_rd_addr_i   = AW'(rd);
      de_reg_write_i = rw;
      de_is_load_i   = ld;
      cnt_clr_i      = clr;
      if (r) begin
         m_de_v = 0; m_mw_v = 0; m_mw_rw = 0; m_mw_ld = 0;
         m_mw_rd = 0; m_age = 0; m_scnt = 0; m_fcnt = 0;
         wb_q.delete();
      end
      // A load occupies MW for LAT cycles and holds the pipe for all but the last
      e.stall = m_mw_v && m_mw_ld && (m_age < LAT);
      e.flush = redir && m_de_v && !e.stall;
      e.de_v  = m_de_v;
      e.mw_v  = m_mw_v;
      e.fa    = m_de_v && u1 && m_mw_v && m_mw_rw && (m_mw_rd != 0) && (m_mw_rd == rs1);
      e.fb    = m_de_v && u2 && m_mw_v && m_mw_rw && (m_mw_rd != 0) && (m_mw_rd == rs2);
      e.wr    = m_mw_v && m_mw_rw && !e.stall;
      e.mw_rd = m_mw_rd;
      e.scnt  = m_scnt;
      e.fcnt  = m_fcnt;
      exp_q.push_back(e);
      if (!r) begin
         if (clr) begin
            m_scnt = 0;
            m_fcnt = 0;
         end else begin
            if (e.stall && m_scnt < CMAX) m_scnt++;
            if (e.flush && m_fcnt < CMAX) m_fcnt++;
         end
         if (e.stall) begin
            m_age++;
         end else begin
            m_mw_v  = m_de_v;
            m_mw_rd = m_de_v ? rd : 0;
            m_mw_rw = m_de_v && rw;
            m_mw_ld = m_de_v && ld;
            m_age   = 1;
            if (m_mw_rw) wb_q.push_back(m_mw_rd);
            m_de_v  = ifv && !e.flush;
         end
      end
   endtask

   task automatic rand_cycle(input bit allow_rst);
      cycle(allow_rst && ($urandom_range(0, 199) == 0),
            $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
   endtask

   // Monitor: compares what the DUT presents against the queued expectations
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",     stall_o,        e.stall);
            check("pc_en",     pc_en_o,        !e.stall);
            check("if_de_en",  if_de_en_o,     !e.stall);
            check("de_mw_en",  de_mw_en_o,     !e.stall);
            check("flush",     if_de_flush_o,  e.flush);
            check("de_valid",  de_valid_o,     e.de_v);
            check("mw_valid",  mw_valid_o,     e.mw_v);
            check("fwd_a",     fwd_a_o,        e.fa);
            check("fwd_b",     fwd_b_o,        e.fb);
            check("reg_write", mw_reg_write_o, e.wr);
            check("mw_rd",     mw_rd_addr_o,   e.mw_rd);
            check("stall_cnt", stall_cnt_o,    e.scnt);
            check("flush_cnt", flush_cnt_o,    e.fcnt);
         end
         if (mw_reg_write_o) begin
            if (wb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL wb_order: got write to x%0d expected no write pending", mw_rd_addr_o);
            end else begin
               check("wb_rd", mw_rd_addr_o, wb_q.pop_front());
            end
         end
      end
   end

   // Driver: directed scenarios first, then randomized traffic
   initial begin
      repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle(0, 1, 0, 1, 2, 0, 0, 3, 1, 0, 0);
      // x5 producer followed by x5 consumer, then x0 producer/consumer
      cycle(0, 1, 0, 1, 2, 0, 0, 5, 1, 0, 0);
      cycle(0, 1, 0, 5, 6, 1, 1, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0, 1, 1, 9, 1, 0, 0);
      // single-cycle redirect
      cycle(0, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
      // load, then redirect held across its stall
      cycle(0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
      repeat (4) cycle(0, 1, 1, 7, 0, 1, 0, 8, 1, 0, 0);
      repeat (2) cycle(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0);
      // reset while a load holds the pipe
      cycle(0, 1, 0, 0, 0, 0, 0, 6, 1, 1, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
      // back-to-back loads drive the stall counter into saturation, then clear
      cycle(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
      repeat (420) cycle(0, 1, 0, 0, 0, 0, 0, 10, 1, 1, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 10, 1, 0, 1);
      repeat (4) cycle(0, 1, 0, 0, 0, 0, 0, 11, 1, 0, 0);
      repeat (3000) rand_cycle(1'b1);
      repeat (12) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #4;
      check("wb_drain", wb_q.size(), 0);
      check("exp_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
